mem_responder: RTL and testbench

- Memory-side responder for the multi-cycle RISC-V core's split instruction and data channels; answers fetches, loads and byte-strobed stores.
- Backed by one single-port word array shared by both channels, with configurable response latency.
- Sits between custom_cpu and the simulation/FPGA memory model; replaces the ideal memory in the bench.

---
 rtl/mem_resp_pkg.sv | 21 ++
 rtl/mem_resp_array.sv | 27 ++
 rtl/mem_responder.sv | 124 ++++++++++++
 tb/tb_mem_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared encodings for the memory responder: FSM states, request kinds and latency limits.
package mem_resp_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_BUSY = 4'b0010,
        ST_IRSP = 4'b0100,
        ST_DRSP = 4'b1000
    } state_t;

    typedef enum logic [1:0] {
        K_FETCH = 2'd0,
        K_LOAD  = 2'd1,
        K_STORE = 2'd2
    } kind_t;

    localparam int unsigned LAT_MIN = 1;
    localparam int unsigned LAT_MAX = 15;
    localparam int unsigned CNT_W   = $clog2(LAT_MAX + 1);

endpackage

// File: rtl/mem_resp_array.sv
// Single-port 2^ADDR_W x 32 word RAM with byte write enables and a registered read port.
module mem_resp_array #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [3:0]        i_we,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [2**ADDR_W];
    logic [31:0] r_rdata;

    // Read-before-write on the same edge; callers never need the just-written word here.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (i_we[i]) begin
                r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for split fetch/data channels sharing one word array,
// with a fixed accept-to-response latency and a held response until the core accepts it.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    input  logic        Inst_Req_Valid,
    output logic        Inst_Req_Ready,
    output logic [31:0] Instruction,
    output logic        Inst_Valid,
    input  logic        Inst_Ready,
    input  logic [31:0] Address,
    input  logic        MemWrite,
    input  logic [31:0] Write_data,
    input  logic [3:0]  Write_strb,
    input  logic        MemRead,
    output logic        Mem_Req_Ready,
    output logic [31:0] Read_data,
    output logic        Read_data_Valid,
    input  logic        Read_data_Ready
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    kind_t             r_kind;
    kind_t             w_req_kind;
    logic [CNT_W-1:0]  r_count;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_req_idx;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [3:0]        w_ram_we;
    logic [31:0]       w_ram_rdata;
    logic [31:0]       r_inst;
    logic [31:0]       r_rdata;
    logic              w_idle;
    logic              w_data_req;
    logic              w_data_acc;
    logic              w_inst_rdy;
    logic              w_inst_acc;
    logic              w_done;
    logic              w_unused;

    assign w_unused = ^{PC[31:ADDR_W+2], PC[1:0], Address[31:ADDR_W+2], Address[1:0]};

    always_comb begin
        w_idle     = (r_state == ST_IDLE);
        w_data_req = MemRead | MemWrite;
        w_data_acc = w_idle & w_data_req;
        w_inst_rdy = w_idle & ~w_data_req;
        w_inst_acc = w_inst_rdy & Inst_Req_Valid;
        w_done     = (r_state == ST_BUSY) && (r_count == '0);
        w_req_kind = MemWrite ? K_STORE : (MemRead ? K_LOAD : K_FETCH);
        w_req_idx  = w_data_req ? Address[ADDR_W+1:2] : PC[ADDR_W+1:2];
        // In IDLE the RAM sees the incoming request so a store commits at its accept edge.
        w_ram_addr = w_idle ? w_req_idx : r_idx;
        w_ram_we   = (w_data_acc & MemWrite) ? Write_strb : '0;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (w_data_acc || w_inst_acc) w_state_nxt = ST_BUSY;
            ST_BUSY: begin
                if (w_done) begin
                    unique case (r_kind)
                        K_FETCH: w_state_nxt = ST_IRSP;
                        K_LOAD:  w_state_nxt = ST_DRSP;
                        default: w_state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_IRSP: if (Inst_Ready)      w_state_nxt = ST_IDLE;
            ST_DRSP: if (Read_data_Ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_kind  <= K_FETCH;
            r_count <= '0;
            r_idx   <= '0;
            r_inst  <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_data_acc || w_inst_acc) begin
                r_kind  <= w_req_kind;
                r_idx   <= w_req_idx;
                r_count <= CNT_LOAD;
            end else if (r_state == ST_BUSY && r_count != '0) begin
                r_count <= r_count - 1'b1;
            end
            if (w_done && r_kind == K_FETCH) r_inst  <= w_ram_rdata;
            if (w_done && r_kind == K_LOAD)  r_rdata <= w_ram_rdata;
        end
    end

    mem_resp_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .i_addr  (w_ram_addr),
        .i_we    (w_ram_we),
        .i_wdata (Write_data),
        .o_rdata (w_ram_rdata)
    );

    assign Mem_Req_Ready   = w_idle;
    assign Inst_Req_Ready  = w_inst_rdy;
    assign Inst_Valid      = (r_state == ST_IRSP);
    assign Read_data_Valid = (r_state == ST_DRSP);
    assign Instruction     = r_inst;
    assign Read_data       = r_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder at ADDR_W=12, LATENCY=2.
module tb_mem_responder;

    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] PC = '0;
    logic        Inst_Req_Valid = 1'b0;
    logic        Inst_Req_Ready;
    logic [31:0] Instruction;
    logic        Inst_Valid;
    logic        Inst_Ready = 1'b0;
    logic [31:0] Address = '0;
    logic        MemWrite = 1'b0;
    logic [31:0] Write_data = '0;
    logic [3:0]  Write_strb = '0;
    logic        MemRead = 1'b0;
    logic        Mem_Req_Ready;
    logic [31:0] Read_data;
    logic        Read_data_Valid;
    logic        Read_data_Ready = 1'b0;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    mem_responder #(
        .ADDR_W  (12),
        .LATENCY (LAT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .PC              (PC),
        .Inst_Req_Valid  (Inst_Req_Valid),
        .Inst_Req_Ready  (Inst_Req_Ready),
        .Instruction     (Instruction),
        .Inst_Valid      (Inst_Valid),
        .Inst_Ready      (Inst_Ready),
        .Address         (Address),
        .MemWrite        (MemWrite),
        .Write_data      (Write_data),
        .Write_strb      (Write_strb),
        .MemRead         (MemRead),
        .Mem_Req_Ready   (Mem_Req_Ready),
        .Read_data       (Read_data),
        .Read_data_Valid (Read_data_Valid),
        .Read_data_Ready (Read_data_Ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (Mem_Req_Ready) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_idle_timeout"}, 32'(seen), 32'd1);
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        @(negedge clk);
        Address = addr; Write_data = data; Write_strb = strb; MemWrite = 1'b1;
        @(posedge clk); #1;
        MemWrite = 1'b0;
        wait_idle("store");
    endtask

    // Issues a load from IDLE; returns the response word and the number of edges from accept to valid.
    task automatic do_load(input logic [31:0] addr, output logic [31:0] data, output int lat);
        lat = 0;
        data = '0;
        @(negedge clk);
        Address = addr; MemRead = 1'b1;
        @(posedge clk); #1;
        MemRead = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (Read_data_Valid) begin
                data = Read_data;
                break;
            end
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] held;
        int          lat;
        bit          ok;
        bit          early;

        // Reset state
        #12;
        chk("rst_ivalid", 32'(Inst_Valid), 32'd0);
        chk("rst_dvalid", 32'(Read_data_Valid), 32'd0);
        chk("rst_instr", Instruction, 32'h0);
        chk("rst_rdata", Read_data, 32'h0);
        chk("rst_mready", 32'(Mem_Req_Ready), 32'd1);
        chk("rst_iready", 32'(Inst_Req_Ready), 32'd1);
        @(negedge clk); rst = 1'b1;

        // Fetch at LATENCY=2 from index 1
        do_store(32'h4, 32'h0000_0013, 4'hF);
        @(negedge clk);
        PC = 32'h4; Inst_Req_Valid = 1'b1; Inst_Ready = 1'b1;
        @(posedge clk); #1;
        Inst_Req_Valid = 1'b0;
        lat = 0; ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (Inst_Valid) begin ok = 1'b1; break; end
        end
        chk("fetch_seen", 32'(ok), 32'd1);
        chk("fetch_lat", 32'(lat), 32'(LAT));
        chk("fetch_data", Instruction, 32'h0000_0013);
        @(negedge clk);
        chk("fetch_1cyc", 32'(Inst_Valid), 32'd0);
        chk("fetch_idle", 32'(Inst_Req_Ready), 32'd1);

        // Byte store merge, then load
        Read_data_Ready = 1'b1;
        do_store(32'h100, 32'h1122_3344, 4'hF);
        do_store(32'h102, 32'hAAAA_AAAA, 4'b0100);
        do_load(32'h100, d, lat);
        chk("merge_data", d, 32'h11AA_3344);
        chk("load_lat", 32'(lat), 32'(LAT));

        // Zero-strobe store: memory unchanged, still LAT busy cycles
        @(negedge clk);
        Address = 32'h100; Write_data = 32'h0; Write_strb = 4'h0; MemWrite = 1'b1;
        @(posedge clk); #1;
        MemWrite = 1'b0;
        @(negedge clk); chk("strb0_busy0", 32'(Mem_Req_Ready), 32'd0);
        @(negedge clk); chk("strb0_busy1", 32'(Mem_Req_Ready), 32'd0);
        @(negedge clk); chk("strb0_idle", 32'(Mem_Req_Ready), 32'd1);
        do_load(32'h100, d, lat);
        chk("strb0_data", d, 32'h11AA_3344);

        // Backpressure on load response
        @(negedge clk);
        Read_data_Ready = 1'b0;
        do_load(32'h4, d, lat);
        chk("bp_data", d, 32'h0000_0013);
        held = Read_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(Read_data_Valid), 32'd1);
            chk("bp_hold", Read_data, held);
            chk("bp_mready", 32'(Mem_Req_Ready), 32'd0);
        end
        Read_data_Ready = 1'b1;
        @(negedge clk);
        chk("bp_drop", 32'(Read_data_Valid), 32'd0);
        chk("bp_release", 32'(Mem_Req_Ready), 32'd1);
        chk("bp_keep", Read_data, 32'h0000_0013);

        // Simultaneous fetch and load: load wins
        @(negedge clk);
        PC = 32'h100; Inst_Req_Valid = 1'b1; Address = 32'h4; MemRead = 1'b1;
        #1;
        chk("sim_iready", 32'(Inst_Req_Ready), 32'd0);
        chk("sim_mready", 32'(Mem_Req_Ready), 32'd1);
        @(posedge clk); #1;
        MemRead = 1'b0;
        ok = 1'b0; early = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (Inst_Valid) early = 1'b1;
            if (Read_data_Valid) begin ok = 1'b1; break; end
        end
        chk("sim_load_seen", 32'(ok), 32'd1);
        chk("sim_load_data", Read_data, 32'h0000_0013);
        chk("sim_no_early_fetch", 32'(early), 32'd0);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (Inst_Req_Ready) begin
                @(posedge clk); #1;
                Inst_Req_Valid = 1'b0;
                ok = 1'b1;
                break;
            end
        end
        chk("sim_fetch_accept", 32'(ok), 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (Inst_Valid) begin ok = 1'b1; break; end
        end
        chk("sim_fetch_seen", 32'(ok), 32'd1);
        chk("sim_fetch_data", Instruction, 32'h11AA_3344);
        Inst_Req_Valid = 1'b0;
        wait_idle("sim");

        // Address wrap and low-bit alignment
        do_store(32'h0000_4000, 32'hDEAD_BEEF, 4'hF);
        do_load(32'h0000_0003, d, lat);
        chk("wrap_data", d, 32'hDEAD_BEEF);

        // Reset mid-BUSY; memory survives
        @(negedge clk);
        Address = 32'h100; MemRead = 1'b1;
        @(posedge clk); #1;
        MemRead = 1'b0;
        @(negedge clk);
        chk("mid_busy", 32'(Mem_Req_Ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("mid_rst_mready", 32'(Mem_Req_Ready), 32'd1);
        chk("mid_rst_rdata", Read_data, 32'h0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("post_rst_dvalid", 32'(Read_data_Valid), 32'd0);
        chk("post_rst_ivalid", 32'(Inst_Valid), 32'd0);
        chk("post_rst_mready", 32'(Mem_Req_Ready), 32'd1);
        chk("post_rst_iready", 32'(Inst_Req_Ready), 32'd1);
        do_load(32'h0, d, lat);
        chk("post_rst_mem", d, 32'hDEAD_BEEF);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
